// File: rtl/ssp_tx_logic.sv
// SSP transmit path: pulls bytes from a transmit FIFO and serialises them MSB first
// behind a two-cycle frame-sync pulse, with a free-running PCLK/2 serial clock.
module ssp_tx_logic (
   input  logic       PCLK,
   input  logic       CLEAR,
   input  logic [7:0] TxDATA,
   input  logic       VALID,
   output logic       SENT,
   output logic       SSPCLKOUT,
   output logic       SSPFSSOUT,
   output logic       SSPTXD,
   output logic       SSPOE_B
);

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 5;
   localparam logic [CNT_W-1:0] CNT_FSS_LAST  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_DATA_LAST = CNT_W'(17);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_LOAD = 3'd2,
      S_FSS  = 3'd3,
      S_DATA = 3'd4
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_nxt;
   logic [DATA_W-1:0]   shreg;
   logic [DATA_W-1:0]   shreg_nxt;
   logic                armed;
   logic                fss_d;
   logic                txd_d;
   logic                oe_b_d;

   // Serial clock divider; armed blocks a frame request on the first edge after reset release
   always_ff @(posedge PCLK or posedge CLEAR) begin
      if (CLEAR) begin
         SSPCLKOUT <= 1'b0;
         armed     <= 1'b0;
      end else begin
         SSPCLKOUT <= ~SSPCLKOUT;
         armed     <= 1'b1;
      end
   end

   always_ff @(posedge PCLK or posedge CLEAR) begin
      if (CLEAR) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Requests start only while SSPCLKOUT is low so FSS always opens on a rising edge
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (armed && VALID && !SSPCLKOUT) state_nxt = S_REQ;
         S_REQ:  state_nxt = S_LOAD;
         S_LOAD: state_nxt = S_FSS;
         S_FSS:  if (cnt == CNT_FSS_LAST) state_nxt = S_DATA;
         S_DATA: if (cnt == CNT_DATA_LAST) state_nxt = VALID ? S_REQ : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Position counter runs 0..17 over FSS+DATA; shift register advances at each bit end
   always_comb begin
      cnt_nxt   = '0;
      shreg_nxt = shreg;
      if (state == S_LOAD) shreg_nxt = TxDATA;
      if (state == S_DATA && cnt[0]) shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
      if (state == S_FSS || (state == S_DATA && cnt != CNT_DATA_LAST))
         cnt_nxt = cnt + CNT_W'(1);
   end

   always_ff @(posedge PCLK or posedge CLEAR) begin
      if (CLEAR) begin
         cnt   <= '0;
         shreg <= '0;
      end else begin
         cnt   <= cnt_nxt;
         shreg <= shreg_nxt;
      end
   end

   // Serial outputs are computed from the next state so the registers line up with it
   always_comb begin
      fss_d  = 1'b0;
      txd_d  = 1'b0;
      oe_b_d = 1'b1;
      if (state_nxt == S_FSS) begin
         fss_d  = 1'b1;
         oe_b_d = 1'b0;
      end
      if (state_nxt == S_DATA) begin
         txd_d  = shreg_nxt[DATA_W-1];
         oe_b_d = 1'b0;
      end
   end

   always_ff @(posedge PCLK or posedge CLEAR) begin
      if (CLEAR) begin
         SSPFSSOUT <= 1'b0;
         SSPTXD    <= 1'b0;
         SSPOE_B   <= 1'b1;
      end else begin
         SSPFSSOUT <= fss_d;
         SSPTXD    <= txd_d;
         SSPOE_B   <= oe_b_d;
      end
   end

   assign SENT = (state == S_REQ);

endmodule
